// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the word-level UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 10 + parity_en + stop_bits - 1;
    endfunction

    // Never returns 0 so a divide/count of 1 still gets a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: tick is high in the last clock of every serial bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    generate
        if (CLKS_PER_BIT <= 1) begin : g_single
            logic w_unused;
            assign w_unused = ^{clk, rst, clear};
            assign tick     = 1'b1;
        end else begin : g_div
            localparam int CW = cnt_width(CLKS_PER_BIT);
            logic [CW-1:0] r_cnt;

            assign tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

            always_ff @(posedge clk) begin
                if (rst || clear || tick)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    endgenerate

endmodule

// File: rtl/uart_word_tx.sv
// Multi-byte UART transmitter: one word per valid/ready handshake,
// sent MSB byte first as back-to-back frames with gapless streaming.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int NUM_BYTES    = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    output logic                   TxD,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = BITS_PER_BYTE * NUM_BYTES;
    localparam int BW = cnt_width(NUM_BYTES);

    state_t          r_state;
    logic [W-1:0]    r_shift;
    logic [2:0]      r_bit;
    logic [BW-1:0]   r_byte;
    logic            r_txd;
    logic            r_busy;
    logic            r_done;

    logic            w_tick;
    logic [7:0]      w_byte;
    logic [2:0]      w_nidx;
    logic            w_first;
    logic            w_next;
    logic            w_parity;
    logic            w_last_stop;
    logic            w_last_byte;
    logic            w_ready;
    logic            w_accept;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(r_state == IDLE),
        .tick (w_tick)
    );

    // Current byte always sits at the top of the shift register.
    assign w_byte      = r_shift[W-1 -: 8];
    assign w_nidx      = r_bit + 3'd1;
    assign w_first     = (LSB_FIRST != 0) ? w_byte[0] : w_byte[7];
    assign w_next      = w_byte[(LSB_FIRST != 0) ? w_nidx : ~w_nidx];
    assign w_parity    = (^w_byte) ^ 1'(PARITY_ODD);
    assign w_last_stop = (r_state == STOP) && (r_bit == 3'(STOP_BITS - 1));
    assign w_last_byte = (r_byte == BW'(NUM_BYTES - 1));
    assign w_ready     = (r_state == IDLE) || (w_last_stop && w_last_byte && w_tick);
    assign w_accept    = valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                // Accepting out of STOP means the previous word just ended.
                r_shift <= data;
                r_byte  <= '0;
                r_bit   <= '0;
                r_state <= START;
                r_txd   <= 1'b0;
                r_busy  <= 1'b1;
                r_done  <= (r_state == STOP);
            end else if (w_tick) begin
                unique case (r_state)
                    IDLE: begin
                        r_txd <= 1'b1;
                    end
                    START: begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_txd   <= w_first;
                    end
                    DATA: begin
                        if (r_bit == 3'd7) begin
                            r_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_txd   <= w_parity;
                            end else begin
                                r_state <= STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit <= w_nidx;
                            r_txd <= w_next;
                        end
                    end
                    PARITY: begin
                        r_state <= STOP;
                        r_bit   <= '0;
                        r_txd   <= 1'b1;
                    end
                    STOP: begin
                        if (!w_last_stop) begin
                            r_bit <= r_bit + 3'd1;
                        end else if (!w_last_byte) begin
                            r_byte  <= r_byte + 1'b1;
                            r_shift <= r_shift << 8;
                            r_bit   <= '0;
                            r_state <= START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_txd   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_txd   <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ready = w_ready;
    assign TxD   = r_txd;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: three parameterisations, hand-built bit streams.
module tb_uart_word_tx;

    logic clk = 1'b0;
    logic rst;

    logic [31:0] d1;
    logic        v1, rdy1, tx1, bsy1, dn1;
    logic [7:0]  d2;
    logic        v2, rdy2, tx2, bsy2, dn2;
    logic [31:0] d3;
    logic        v3, rdy3, tx3, bsy3, dn3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_word_tx u_def (
        .clk  (clk),
        .rst  (rst),
        .data (d1),
        .valid(v1),
        .ready(rdy1),
        .TxD  (tx1),
        .busy (bsy1),
        .done (dn1)
    );

    uart_word_tx #(
        .NUM_BYTES   (1),
        .CLKS_PER_BIT(4),
        .PARITY_EN   (1),
        .PARITY_ODD  (0),
        .STOP_BITS   (1),
        .LSB_FIRST   (1)
    ) u_par (
        .clk  (clk),
        .rst  (rst),
        .data (d2),
        .valid(v2),
        .ready(rdy2),
        .TxD  (tx2),
        .busy (bsy2),
        .done (dn2)
    );

    uart_word_tx #(
        .STOP_BITS(2)
    ) u_stop (
        .clk  (clk),
        .rst  (rst),
        .data (d3),
        .valid(v3),
        .ready(rdy3),
        .TxD  (tx3),
        .busy (bsy3),
        .done (dn3)
    );

    task automatic test_reset();
        rst = 1'b1;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        d1 = '0; d2 = '0; d3 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx1, rdy1, bsy1, dn1} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_def: txd/rdy/busy/done=%b want 1100", {tx1, rdy1, bsy1, dn1});
        end
        checks++;
        if ({tx2, rdy2, bsy2, dn2} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_par: txd/rdy/busy/done=%b want 1100", {tx2, rdy2, bsy2, dn2});
        end
        checks++;
        if ({tx3, rdy3, bsy3, dn3} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_stop: txd/rdy/busy/done=%b want 1100", {tx3, rdy3, bsy3, dn3});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word(input logic [31:0] d, input logic [39:0] s, input string nm);
        checks++;
        if (rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_idle: ready=%b want 1", nm, rdy1);
        end
        d1 = d;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({tx1, bsy1, dn1} !== {s[39-i], 2'b10}) begin
                errors++;
                $display("FAIL %s_bit%0d: txd/busy/done=%b want %b",
                         nm, i, {tx1, bsy1, dn1}, {s[39-i], 2'b10});
            end
            @(negedge clk);
        end
        checks++;
        if ({tx1, rdy1, bsy1, dn1} !== 4'b1101) begin
            errors++;
            $display("FAIL %s_done: txd/rdy/busy/done=%b want 1101", nm, {tx1, rdy1, bsy1, dn1});
        end
        @(negedge clk);
        checks++;
        if (dn1 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b want 0", nm, dn1);
        end
    endtask

    task automatic test_parity_baud();
        logic [10:0] s;
        s = 11'b01110000011;
        d2 = 8'h07;
        v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        for (int c = 0; c < 44; c++) begin
            checks++;
            if ({tx2, bsy2, dn2} !== {s[10 - c/4], 2'b10}) begin
                errors++;
                $display("FAIL par_clk%0d: txd/busy/done=%b want %b",
                         c, {tx2, bsy2, dn2}, {s[10 - c/4], 2'b10});
            end
            @(negedge clk);
        end
        checks++;
        if ({tx2, rdy2, bsy2, dn2} !== 4'b1101) begin
            errors++;
            $display("FAIL par_done: txd/rdy/busy/done=%b want 1101", {tx2, rdy2, bsy2, dn2});
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [79:0] s;
        s = 80'b0000100011_0001000101_0001100111_0010001001_0010101011_0011001101_0011101111_0100010001;
        d1 = 32'h11223344;
        v1 = 1'b1;
        @(negedge clk);
        d1 = 32'h55667788;
        for (int i = 0; i < 80; i++) begin
            checks++;
            if ({tx1, bsy1, dn1} !== {s[79-i], 1'b1, (i == 40)}) begin
                errors++;
                $display("FAIL b2b_bit%0d: txd/busy/done=%b want %b",
                         i, {tx1, bsy1, dn1}, {s[79-i], 1'b1, (i == 40)});
            end
            if (i == 39 || i == 20) begin
                checks++;
                if (rdy1 !== (i == 39)) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: ready=%b want %b", i, rdy1, (i == 39));
                end
            end
            if (i == 40) v1 = 1'b0;
            @(negedge clk);
        end
        checks++;
        if ({tx1, rdy1, bsy1, dn1} !== 4'b1101) begin
            errors++;
            $display("FAIL b2b_done2: txd/rdy/busy/done=%b want 1101", {tx1, rdy1, bsy1, dn1});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d1 = 32'hA5C30F01;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (bsy1 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: busy=%b want 1", bsy1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx1, rdy1, bsy1, dn1} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_abort: txd/rdy/busy/done=%b want 1100", {tx1, rdy1, bsy1, dn1});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if ({tx1, bsy1, dn1} !== 3'b100) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: txd/busy/done=%b want 100", i, {tx1, bsy1, dn1});
            end
        end
    endtask

    task automatic test_stop2_latch();
        logic [43:0] s;
        s = 44'b00001001011_00011010011_00101011011_00111100011;
        d3 = 32'h12345678;
        v3 = 1'b1;
        @(negedge clk);
        d3 = 32'hFFFFFFFF;
        v3 = 1'b0;
        for (int i = 0; i < 44; i++) begin
            if (i == 10) v3 = 1'b1;
            if (i == 11) v3 = 1'b0;
            checks++;
            if ({tx3, bsy3, dn3} !== {s[43-i], 2'b10}) begin
                errors++;
                $display("FAIL stop2_bit%0d: txd/busy/done=%b want %b",
                         i, {tx3, bsy3, dn3}, {s[43-i], 2'b10});
            end
            @(negedge clk);
        end
        checks++;
        if ({tx3, rdy3, bsy3, dn3} !== 4'b1101) begin
            errors++;
            $display("FAIL stop2_done: txd/rdy/busy/done=%b want 1101", {tx3, rdy3, bsy3, dn3});
        end
        @(negedge clk);
        checks++;
        if ({tx3, bsy3, dn3} !== 3'b100) begin
            errors++;
            $display("FAIL stop2_no_extra: txd/busy/done=%b want 100", {tx3, bsy3, dn3});
        end
    endtask

    initial begin
        test_reset();
        test_word(32'hA5C30F01,
                  40'b0101001011_0110000111_0000011111_0000000011, "word_a5");
        test_word(32'h00000000,
                  40'b0000000001_0000000001_0000000001_0000000001, "word_zero");
        test_parity_baud();
        test_back_to_back();
        test_reset_mid();
        test_word(32'h0F0F0F0F,
                  40'b0000011111_0000011111_0000011111_0000011111, "after_rst");
        test_stop2_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
